hex_display_arbiter: RTL and testbench
======================================

HEX_DISPLAY_ARBITER -- requirements
Module: hex_display_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, minimum cycles a grant is held before preemption or release; legal range 1..255.
REQ-002 KEY0  input  1  clock; all state updates on the rising edge.
REQ-003 KEY1  input  1  reset, asynchronous, active-low.
REQ-004 REQ_A  input  1  requester A wants the displays; level, held while wanted.
REQ-005 DATA_A  input  16  requester A value, nibble [4k+3:4k] shown on HEXk.
REQ-006 REQ_B  input  1  requester B wants the displays.
REQ-007 DATA_B  input  16  requester B value, same nibble mapping.
REQ-008 GNT_A  output  1  A owns the displays.
REQ-009 GNT_B  output  1  B owns the displays.
REQ-010 HEX0..HEX3  output  7 each  seven-segment drive, active-low, bit 0 = segment a ... bit 6 = segment g.
REQ-011 LEDR_BUSY  output  1  high while either grant is asserted.

Function
REQ-012 FSM states: IDLE, GRANT_A, GRANT_B, RELEASE; all outputs registered.
REQ-013 IDLE: if any REQ high, enter GRANT_x chosen per REQ-019/020 on next edge; else stay.
REQ-014 On entry to GRANT_x, GNT_x asserts in the same cycle the state is entered (one cycle after REQ sampled high); the other GNT stays 0; GNT_A and GNT_B are never both 1.
REQ-015 In GRANT_x, HEXk shows hex-decoded DATA_x nibble k sampled at the previous edge (one-cycle latency, live tracking); digits 0-F use the standard 7-seg glyphs (A,b,C,d,E,F).
REQ-016 Hold counter loads 0 on grant entry, increments each granted cycle, saturates at HOLD_CYCLES.
REQ-017 GRANT_x to RELEASE when REQ_x low (any time, hold ignored), or when counter == HOLD_CYCLES and the other requester is high and allowed to preempt (REQ-019/020).
REQ-018 RELEASE lasts exactly one cycle: both GNT 0, HEX all 7'h7F (blank), LEDR_BUSY 0; then arbitrate as in IDLE using current REQs (may return directly to a GRANT state).
REQ-019 Arbitration with ROUND_ROBIN_EN: single request wins; simultaneous requests go to the requester not granted most recently; preemption allowed for either side.
REQ-020 Arbitration without ROUND_ROBIN_EN: A wins ties; A may preempt B after hold; B never preempts A.
REQ-021 DATA changes never affect grant decisions; REQ toggling within a cycle is not detected.

Reset
REQ-022 KEY1 low: immediately state IDLE, GNT_A=GNT_B=0, LEDR_BUSY=0, HEX0..HEX3=7'h7F, hold counter 0, last-granted pointer = B (A wins first tie).
REQ-023 Reset during GRANT_x drops the grant asynchronously; after KEY1 rises, first grant follows REQ-013 from IDLE.

Configuration
REQ-024 Macro HEX_ARB_ROUND_ROBIN_EN defined: REQ-019 behaviour and the last-granted pointer flop exist.
REQ-025 Macro undefined: REQ-020 fixed priority, no pointer flop; all other behaviour identical.

Structure
REQ-026 Package hex_arb_pkg holds the state enum, SEG_BLANK = 7'h7F and the 16-entry glyph constants.
REQ-027 Sub-module hex7seg (4-bit in, 7-bit active-low out, combinational) instantiated four times; registers stay in hex_display_arbiter.

Verification
REQ-028 Reset then REQ_A=1, DATA_A=16'h1234 -> GNT_A=1 next cycle, then HEX3..HEX0 = 1,2,3,4 glyphs (7'h79,7'h24,7'h30,7'h19).
REQ-029 REQ_A and REQ_B rise together after reset -> A granted; A drops -> RELEASE one cycle blank -> B granted; repeat tie (macro on) -> B then A alternately.
REQ-030 HOLD_CYCLES=4, A granted, REQ_B rises on grant cycle 1 -> GNT_A stays high 4 cycles, RELEASE, GNT_B (macro on); macro off: GNT_A held until REQ_A falls.
REQ-031 Macro off, B granted, REQ_A rises -> B kept for 4 cycles, then RELEASE and A granted.
REQ-032 KEY1 pulsed low mid-grant -> GNT, LEDR_BUSY drop and HEX = 7'h7F without waiting for a clock edge; both grants never high together in any cycle (assertion).

Source files
------------

// File: rtl/hex_arb_pkg.sv
// hex_display_arbiter shared types and seven-segment glyph constants.
// Segment encoding is active-low with bit 0 = a through bit 6 = g.
package hex_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      GRANT_A,
      GRANT_B,
      RELEASE
   } arb_state_e;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Glyphs 0..F, index 0 in the least significant slot.
   localparam logic [15:0][6:0] SEG_GLYPH = {
      7'h0E, 7'h06, 7'h21, 7'h46,
      7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19,
      7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/hex7seg.sv
// hex7seg: combinational nibble to active-low seven-segment glyph.
// Shows 0-9 and A,b,C,d,E,F.
module hex7seg
   import hex_arb_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);

   assign seg_o = SEG_GLYPH[nib_i];

endmodule

// File: rtl/hex_display_arbiter.sv
// hex_display_arbiter: two requesters share four hex digits with a hold time.
// Define HEX_ARB_ROUND_ROBIN_EN for round-robin ties and two-way preemption.
module hex_display_arbiter
   import hex_arb_pkg::*;
#(
   parameter int HOLD_CYCLES = 4
) (
   input  logic        KEY0,
   input  logic        KEY1,
   input  logic        REQ_A,
   input  logic [15:0] DATA_A,
   input  logic        REQ_B,
   input  logic [15:0] DATA_B,
   output logic        GNT_A,
   output logic        GNT_B,
   output logic [6:0]  HEX0,
   output logic [6:0]  HEX1,
   output logic [6:0]  HEX2,
   output logic [6:0]  HEX3,
   output logic        LEDR_BUSY
);

   localparam logic [7:0] HOLD_MAX  = 8'(HOLD_CYCLES);
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

   arb_state_e       state_q, state_d;
   arb_state_e       pick;
   logic [7:0]       cnt_q, cnt_d;
   logic             gnt_a_q, gnt_a_d;
   logic             gnt_b_q, gnt_b_d;
   logic             busy_q, busy_d;
   logic [3:0][6:0]  hex_q, hex_d;
   logic [3:0][6:0]  seg;
   logic [15:0]      data_sel;
   logic             hold_met;
   logic             tie_a;
   logic             b_may_preempt;

`ifdef HEX_ARB_ROUND_ROBIN_EN
   logic last_a_q, last_a_d;

   assign tie_a         = ~last_a_q;
   assign b_may_preempt = 1'b1;

   // Remember which side was granted most recently.
   always_comb begin
      last_a_d = last_a_q;
      if (state_d == GRANT_A) last_a_d = 1'b1;
      else if (state_d == GRANT_B) last_a_d = 1'b0;
   end

   // Pointer starts at B so A wins the first tie.
   always_ff @(posedge KEY0 or negedge KEY1) begin
      if (!KEY1) last_a_q <= 1'b0;
      else       last_a_q <= last_a_d;
   end
`else
   assign tie_a         = 1'b1;
   assign b_may_preempt = 1'b0;
`endif

   // Grant is held for HOLD_CYCLES cycles once this edge completes one more.
   assign hold_met = (cnt_q >= HOLD_LAST);

   // Winner among current requests when the displays are free.
   always_comb begin
      pick = IDLE;
      if (REQ_A && REQ_B) pick = tie_a ? GRANT_A : GRANT_B;
      else if (REQ_A)     pick = GRANT_A;
      else if (REQ_B)     pick = GRANT_B;
   end

   // Next-state logic and hold counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      unique case (state_q)
         IDLE, RELEASE: state_d = pick;
         GRANT_A: begin
            if (!REQ_A)
               state_d = RELEASE;
            else if (hold_met && REQ_B && b_may_preempt)
               state_d = RELEASE;
         end
         GRANT_B: begin
            if (!REQ_B)
               state_d = RELEASE;
            else if (hold_met && REQ_A)
               state_d = RELEASE;
         end
         default: state_d = IDLE;
      endcase
      if ((state_q == GRANT_A || state_q == GRANT_B) &&
          state_d == state_q)
         cnt_d = (cnt_q == HOLD_MAX) ? cnt_q : cnt_q + 8'd1;
   end

   assign data_sel = (state_d == GRANT_B) ? DATA_B : DATA_A;

   for (genvar k = 0; k < 4; k++) begin : g_dig
      hex7seg u_seg (
         .nib_i (data_sel[4*k +: 4]),
         .seg_o (seg[k])
      );
   end

   // Output values for the state being entered.
   always_comb begin
      gnt_a_d = (state_d == GRANT_A);
      gnt_b_d = (state_d == GRANT_B);
      busy_d  = gnt_a_d | gnt_b_d;
      for (int k = 0; k < 4; k++)
         hex_d[k] = busy_d ? seg[k] : SEG_BLANK;
   end

   // State, counter and registered outputs.
   always_ff @(posedge KEY0 or negedge KEY1) begin
      if (!KEY1) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         gnt_a_q <= 1'b0;
         gnt_b_q <= 1'b0;
         busy_q  <= 1'b0;
         hex_q   <= {4{SEG_BLANK}};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gnt_a_q <= gnt_a_d;
         gnt_b_q <= gnt_b_d;
         busy_q  <= busy_d;
         hex_q   <= hex_d;
      end
   end

   assign GNT_A     = gnt_a_q;
   assign GNT_B     = gnt_b_q;
   assign LEDR_BUSY = busy_q;
   assign HEX0      = hex_q[0];
   assign HEX1      = hex_q[1];
   assign HEX2      = hex_q[2];
   assign HEX3      = hex_q[3];

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Self-checking bench for hex_display_arbiter against an owner/age model.
// Follows HEX_ARB_ROUND_ROBIN_EN when defined.
module tb_hex_display_arbiter;

   localparam int HOLD = 4;
`ifdef HEX_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        KEY0 = 1'b0;
   logic        KEY1 = 1'b1;
   logic        REQ_A = 1'b0;
   logic        REQ_B = 1'b0;
   logic [15:0] DATA_A = '0;
   logic [15:0] DATA_B = '0;
   logic        GNT_A, GNT_B, LEDR_BUSY;
   logic [6:0]  HEX0, HEX1, HEX2, HEX3;

   int ncmp = 0;
   int nbad = 0;

   // Model: who owns the displays (0 none, 1 A, 2 B), completed
   // granted cycles, most recent winner, expected digits.
   int         m_owner;
   int         m_age;
   int         m_last;
   logic [6:0] m_hex [4];

   logic [6:0] glyph [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   hex_display_arbiter #(.HOLD_CYCLES(HOLD)) dut (
      .KEY0      (KEY0),
      .KEY1      (KEY1),
      .REQ_A     (REQ_A),
      .DATA_A    (DATA_A),
      .REQ_B     (REQ_B),
      .DATA_B    (DATA_B),
      .GNT_A     (GNT_A),
      .GNT_B     (GNT_B),
      .HEX0      (HEX0),
      .HEX1      (HEX1),
      .HEX2      (HEX2),
      .HEX3      (HEX3),
      .LEDR_BUSY (LEDR_BUSY)
   );

   always #5 KEY0 = ~KEY0;

   task automatic model_reset();
      m_owner = 0;
      m_age   = 0;
      m_last  = 2;
      for (int k = 0; k < 4; k++) m_hex[k] = 7'h7F;
   endtask

   task automatic model_edge();
      bit          ra, rb, own_req, oth_req, may;
      logic [15:0] d;
      int          win;
      ra = REQ_A;
      rb = REQ_B;
      if (m_owner == 0) begin
         win = 0;
         if (ra && rb)  win = (RR && m_last == 1) ? 2 : 1;
         else if (ra)   win = 1;
         else if (rb)   win = 2;
         m_owner = win;
         m_age   = 0;
         if (win != 0) m_last = win;
      end else begin
         own_req = (m_owner == 1) ? ra : rb;
         oth_req = (m_owner == 1) ? rb : ra;
         may     = RR || (m_owner == 2);
         if (!own_req || (m_age + 1 >= HOLD && oth_req && may)) begin
            m_owner = 0;
            m_age   = 0;
         end else begin
            m_age++;
         end
      end
      d = (m_owner == 2) ? DATA_B : DATA_A;
      for (int k = 0; k < 4; k++)
         m_hex[k] = (m_owner == 0) ? 7'h7F : glyph[d[4*k +: 4]];
   endtask

   task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nbad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("gnt_a", 16'(GNT_A), 16'(m_owner == 1));
      chk("gnt_b", 16'(GNT_B), 16'(m_owner == 2));
      chk("busy",  16'(LEDR_BUSY), 16'(m_owner != 0));
      chk("mutex", 16'(GNT_A & GNT_B), 16'd0);
      chk("hex0",  16'(HEX0), 16'(m_hex[0]));
      chk("hex1",  16'(HEX1), 16'(m_hex[1]));
      chk("hex2",  16'(HEX2), 16'(m_hex[2]));
      chk("hex3",  16'(HEX3), 16'(m_hex[3]));
   endtask

   task automatic step();
      @(posedge KEY0);
      model_edge();
      @(negedge KEY0);
      check_all();
   endtask

   task automatic steps(int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Pulse reset in the middle of a low clock phase, check async drop.
   task automatic mid_reset();
      #2;
      KEY1 = 1'b0;
      #1;
      model_reset();
      chk("rst_gnt_a", 16'(GNT_A), 16'd0);
      chk("rst_gnt_b", 16'(GNT_B), 16'd0);
      chk("rst_busy",  16'(LEDR_BUSY), 16'd0);
      chk("rst_hex",   16'({HEX3, HEX2, HEX1, HEX0} == {4{7'h7F}}), 16'd1);
      @(negedge KEY0);
      KEY1 = 1'b1;
   endtask

   initial begin
      model_reset();
      #3;
      KEY1 = 1'b0;
      #1;
      check_all();
      @(negedge KEY0);
      KEY1 = 1'b1;
      steps(2);

      // Single A request with 1234
      REQ_A  = 1'b1;
      DATA_A = 16'h1234;
      step();
      chk("d_gnt_a", 16'(GNT_A), 16'd1);
      chk("d_hex3",  16'(HEX3), 16'h79);
      chk("d_hex2",  16'(HEX2), 16'h24);
      chk("d_hex1",  16'(HEX1), 16'h30);
      chk("d_hex0",  16'(HEX0), 16'h19);
      DATA_A = 16'hABCD;
      steps(2);
      DATA_A = 16'hEF90;
      step();
      REQ_A = 1'b0;
      steps(2);

      // Simultaneous requests, then A drops
      REQ_A = 1'b1;
      REQ_B = 1'b1;
      DATA_B = 16'h5678;
      step();
      chk("tie_first_a", 16'(GNT_A), 16'd1);
      steps(2);
      REQ_A = 1'b0;
      step();
      chk("release_blank", 16'(HEX0), 16'h7F);
      step();
      chk("then_b", 16'(GNT_B), 16'd1);
      REQ_A = 1'b1;
      steps(8);
      REQ_A = 1'b0;
      REQ_B = 1'b0;
      steps(2);

      // Repeated ties
      for (int r = 0; r < 4; r++) begin
         REQ_A = 1'b1;
         REQ_B = 1'b1;
         steps(2);
         REQ_A = 1'b0;
         REQ_B = 1'b0;
         steps(2);
      end

      // B rises on grant cycle 1 of A
      REQ_A = 1'b1;
      step();
      REQ_B = 1'b1;
      steps(8);
      REQ_A = 1'b0;
      steps(3);
      REQ_B = 1'b0;
      steps(2);

      // B granted, A rises
      REQ_B = 1'b1;
      step();
      REQ_A = 1'b1;
      steps(8);
      REQ_A = 1'b0;
      REQ_B = 1'b0;
      steps(2);

      // Reset during a grant
      REQ_A = 1'b1;
      steps(3);
      mid_reset();
      steps(3);
      REQ_A = 1'b0;
      steps(2);

      // Random traffic
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(3) == 0) REQ_A = ~REQ_A;
         if ($urandom_range(3) == 0) REQ_B = ~REQ_B;
         DATA_A = 16'($urandom);
         DATA_B = 16'($urandom);
         if ($urandom_range(99) == 0) mid_reset();
         else step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end

endmodule
